// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end: pixel width and the row-fill FSM.
package sobel_pkg;

  localparam int PIX_W_C = 8;

  typedef enum logic [1:0] {
    FILL0  = 2'd0,
    FILL1  = 2'd1,
    STREAM = 2'd2
  } row_state_t;

  // Row state that follows a completed line.
  function automatic row_state_t next_row_state(input row_state_t s);
    case (s)
      FILL0:   next_row_state = FILL1;
      FILL1:   next_row_state = STREAM;
      default: next_row_state = STREAM;
    endcase
  endfunction

endpackage

// File: rtl/sync_ram_block.sv
// Single-clock RAM: port A read/write with read-old-data, port B write-only.
module sync_ram_block #(
  parameter int WIDTH_P = 8,
  parameter int DEPTH_P = 640,
  localparam int AW_P = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               a_en_i,
  input  logic               a_we_i,
  input  logic [AW_P-1:0]    a_addr_i,
  input  logic [WIDTH_P-1:0] a_wdata_i,
  output logic [WIDTH_P-1:0] a_rdata_o,
  input  logic               b_we_i,
  input  logic [AW_P-1:0]    b_addr_i,
  input  logic [WIDTH_P-1:0] b_wdata_i
);

  logic [WIDTH_P-1:0] r_mem [DEPTH_P];
  logic [WIDTH_P-1:0] r_rdata;

  // Only the read register is reset; the array itself keeps stale contents.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_rdata <= '0;
    end else if (a_en_i) begin
      r_rdata <= r_mem[a_addr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (a_en_i && a_we_i) begin
      r_mem[a_addr_i] <= a_wdata_i;
    end
    if (b_we_i) begin
      r_mem[b_addr_i] <= b_wdata_i;
    end
  end

  assign a_rdata_o = r_rdata;

endmodule

// File: rtl/line_buffer_3row.sv
// Three-row line buffer: presents a vertical 3-pixel column per accepted pixel,
// using two line RAMs for the previous two rows.
module line_buffer_3row
  import sobel_pkg::*;
#(
  parameter int WIDTH_P    = PIX_W_C,
  parameter int LINE_LEN_P = 640,
  localparam int COL_W_P   = $clog2(LINE_LEN_P)
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [WIDTH_P-1:0] pix_i,
  input  logic               valid_i,
  input  logic               sof_i,
  output logic               ready_o,
  output logic [WIDTH_P-1:0] top_o,
  output logic [WIDTH_P-1:0] mid_o,
  output logic [WIDTH_P-1:0] bot_o,
  output logic [COL_W_P-1:0] col_o,
  output logic               eol_o,
  output logic               win_ok_o,
  output logic               valid_o,
  input  logic               ready_i,
  output row_state_t         dbg_state_o
);

  localparam logic [COL_W_P-1:0] LAST_COL_C = COL_W_P'(LINE_LEN_P - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; ready_o depends only on registered valid_o, ready_i and reset.
  logic               w_accept;
  logic               w_last;
  logic [COL_W_P-1:0] w_col;
  logic [COL_W_P-1:0] w_col_nxt;
  row_state_t         w_state_pix;
  row_state_t         w_state_nxt;
  logic [WIDTH_P-1:0] w_ram_a_rd;
  logic [WIDTH_P-1:0] w_ram_b_rd;

  logic [COL_W_P-1:0] r_col_cnt;
  row_state_t         r_state;
  logic               r_valid;
  logic [WIDTH_P-1:0] r_bot;
  logic [COL_W_P-1:0] r_col;
  logic               r_eol;
  logic               r_win_ok;
  logic               r_wb_pend;
  logic [COL_W_P-1:0] r_wb_addr;

  assign ready_o  = rstn_i && (!r_valid || ready_i);
  assign w_accept = valid_i && ready_o;

  // A start-of-frame pixel restarts the raster at row 0, column 0.
  always_comb begin
    w_col       = sof_i ? '0 : r_col_cnt;
    w_state_pix = sof_i ? FILL0 : r_state;
    w_last      = (w_col == LAST_COL_C);
    w_col_nxt   = w_last ? '0 : w_col + COL_W_P'(1);
    w_state_nxt = w_last ? next_row_state(w_state_pix) : w_state_pix;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_col_cnt <= '0;
      r_state   <= FILL0;
      r_valid   <= 1'b0;
      r_bot     <= '0;
      r_col     <= '0;
      r_eol     <= 1'b0;
      r_win_ok  <= 1'b0;
      r_wb_pend <= 1'b0;
      r_wb_addr <= '0;
    end else begin
      r_wb_pend <= w_accept;
      if (w_accept) begin
        r_wb_addr <= w_col;
        r_col_cnt <= w_col_nxt;
        r_state   <= w_state_nxt;
        r_bot     <= pix_i;
        r_col     <= w_col;
        r_eol     <= w_last;
        r_win_ok  <= (w_state_pix == STREAM);
        r_valid   <= 1'b1;
      end else if (ready_i) begin
        r_valid   <= 1'b0;
      end
    end
  end

  // RAM_A holds row n-1: read old value and overwrite with the new pixel.
  sync_ram_block #(
    .WIDTH_P (WIDTH_P),
    .DEPTH_P (LINE_LEN_P)
  ) u_ram_a (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .a_en_i    (w_accept),
    .a_we_i    (1'b1),
    .a_addr_i  (w_col),
    .a_wdata_i (pix_i),
    .a_rdata_o (w_ram_a_rd),
    .b_we_i    (1'b0),
    .b_addr_i  ('0),
    .b_wdata_i ('0)
  );

  // RAM_B holds row n-2: the row leaving RAM_A is written one cycle later,
  // independent of backpressure, at an address never read in that cycle.
  sync_ram_block #(
    .WIDTH_P (WIDTH_P),
    .DEPTH_P (LINE_LEN_P)
  ) u_ram_b (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .a_en_i    (w_accept),
    .a_we_i    (1'b0),
    .a_addr_i  (w_col),
    .a_wdata_i ('0),
    .a_rdata_o (w_ram_b_rd),
    .b_we_i    (r_wb_pend),
    .b_addr_i  (r_wb_addr),
    .b_wdata_i (w_ram_a_rd)
  );

  assign top_o       = w_ram_b_rd;
  assign mid_o       = w_ram_a_rd;
  assign bot_o       = r_bot;
  assign col_o       = r_col;
  assign eol_o       = r_eol;
  assign win_ok_o    = r_win_ok;
  assign valid_o     = r_valid;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed bench for line_buffer_3row (WIDTH 8, line length 4) with a
// raster-position model feeding an expected queue and a negedge monitor.
module tb_line_buffer_3row;
  import sobel_pkg::*;

  localparam int W   = 8;
  localparam int LEN = 4;
  localparam int CW  = 2;

  logic          clk;
  logic          rstn_i;
  logic [W-1:0]  pix_i;
  logic          valid_i;
  logic          sof_i;
  logic          ready_o;
  logic [W-1:0]  top_o;
  logic [W-1:0]  mid_o;
  logic [W-1:0]  bot_o;
  logic [CW-1:0] col_o;
  logic          eol_o;
  logic          win_ok_o;
  logic          valid_o;
  logic          ready_i;
  row_state_t    dbg_state;

  line_buffer_3row #(
    .WIDTH_P    (W),
    .LINE_LEN_P (LEN)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn_i),
    .pix_i       (pix_i),
    .valid_i     (valid_i),
    .sof_i       (sof_i),
    .ready_o     (ready_o),
    .top_o       (top_o),
    .mid_o       (mid_o),
    .bot_o       (bot_o),
    .col_o       (col_o),
    .eol_o       (eol_o),
    .win_ok_o    (win_ok_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0]  bot;
    logic [W-1:0]  top;
    logic [W-1:0]  mid;
    logic [CW-1:0] col;
    logic          eol;
    logic          win_ok;
    row_state_t    state;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] frame_pix [64];
  int           idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic row_state_t row_of(input int i);
    int r;
    r = i / LEN;
    if (r == 0)      row_of = FILL0;
    else if (r == 1) row_of = FILL1;
    else             row_of = STREAM;
  endfunction

  // Expected column from raster position: two rows up and one row up.
  task automatic model_push(input logic [W-1:0] p, input logic s);
    exp_t e;
    if (s) idx = 0;
    e.bot    = p;
    e.col    = CW'(idx % LEN);
    e.eol    = ((idx % LEN) == LEN - 1);
    e.win_ok = (idx >= 2 * LEN);
    e.top    = e.win_ok ? frame_pix[idx - 2 * LEN] : '0;
    e.mid    = e.win_ok ? frame_pix[idx - LEN] : '0;
    e.state  = row_of(idx + 1);
    exp_q.push_back(e);
    frame_pix[idx] = p;
    if (idx < 63) idx++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pix(input logic [W-1:0] p, input logic s);
    int waited;
    valid_i = 1'b1;
    pix_i   = p;
    sof_i   = s;
    waited  = 0;
    @(negedge clk);
    while (!ready_o && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout pixel=%0d actual=ready_low required=accept", p);
    end else begin
      model_push(p, s);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    sof_i   = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rstn_i  = 1'b0;
    valid_i = 1'b0;
    sof_i   = 1'b0;
    @(negedge clk);
    check("rst_ready_pre", ready_o, 0);
    repeat (cycles) @(posedge clk);
    #1;
    check("rst_valid",  valid_o,  0);
    check("rst_win_ok", win_ok_o, 0);
    check("rst_eol",    eol_o,    0);
    check("rst_col",    col_o,    0);
    check("rst_top",    top_o,    0);
    check("rst_mid",    mid_o,    0);
    check("rst_bot",    bot_o,    0);
    check("rst_state",  dbg_state, FILL0);
    check("rst_ready",  ready_o,  0);
    exp_q.delete();
    idx    = 0;
    rstn_i = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame12(input int bubbles);
    for (int i = 1; i <= 12; i++) begin
      if (bubbles != 0) idle($urandom_range(0, 2));
      send_pix(W'(i), i == 1);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  exp_t        mon_e;
  logic        prev_stall = 1'b0;
  logic [28:0] snap;

  always @(negedge clk) begin
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=bot %0d required=none", bot_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("bot",    bot_o,     mon_e.bot);
        check("col",    col_o,     mon_e.col);
        check("eol",    eol_o,     mon_e.eol);
        check("win_ok", win_ok_o,  mon_e.win_ok);
        check("state",  dbg_state, mon_e.state);
        if (mon_e.win_ok) begin
          check("top", top_o, mon_e.top);
          check("mid", mid_o, mon_e.mid);
        end
      end
    end
    if (prev_stall && rstn_i) begin
      check("stall_hold", {top_o, mid_o, bot_o, col_o, eol_o, win_ok_o, valid_o}, snap);
    end
    if (rstn_i && valid_o && !ready_i) begin
      check("stall_ready_o", ready_o, 0);
    end
    prev_stall = rstn_i && valid_o && !ready_i;
    snap       = {top_o, mid_o, bot_o, col_o, eol_o, win_ok_o, valid_o};
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn_i  = 1'b0;
    pix_i   = '0;
    valid_i = 1'b0;
    sof_i   = 1'b0;
    ready_i = 1'b1;

    do_reset(2);

    // Frame fill, continuous stream
    send_frame12(0);
    drain();

    // Backpressure in row 2
    fork
      send_frame12(0);
      begin
        repeat (10) @(posedge clk);
        #1;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    drain();

    // Random bubbles on the input
    send_frame12(1);
    drain();

    // SOF on pixel 7 restarts the frame
    for (int i = 1; i <= 6; i++) send_pix(W'(i), i == 1);
    for (int i = 7; i <= 18; i++) send_pix(W'(i), i == 7);
    drain();

    // Reset after pixel 10, then a new frame without sof
    for (int i = 1; i <= 10; i++) send_pix(W'(i), i == 1);
    do_reset(1);
    for (int i = 0; i < 12; i++) send_pix(W'(8'hA0 + i), 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_buffer_3row.md
LINE_BUFFER_3ROW -- requirements
Module: line_buffer_3row

Interface
REQ-001 Parameter WIDTH_P, default 8: pixel width in bits.
REQ-002 Parameter LINE_LEN_P, default 640: pixels per image line; legal range is 2 or more.
REQ-003 clk_i  input  1  single clock; all logic is on the rising edge.
REQ-004 rstn_i  input  1  reset; synchronous, active-low.
REQ-005 pix_i  input  WIDTH_P  incoming pixel, raster order.
REQ-006 valid_i  input  1  pix_i/sof_i are valid this cycle.
REQ-007 sof_i  input  1  start of frame; qualified by valid_i; marks the pixel at row 0, column 0.
REQ-008 ready_o  output  1  block accepts a pixel this cycle.
REQ-009 top_o  output  WIDTH_P  pixel at the same column, two rows up.
REQ-010 mid_o  output  WIDTH_P  pixel at the same column, one row up.
REQ-011 bot_o  output  WIDTH_P  current pixel.
REQ-012 col_o  output  $clog2(LINE_LEN_P)  column index of the output column.
REQ-013 eol_o  output  1  output column is the last column of its line.
REQ-014 win_ok_o  output  1  top_o and mid_o hold real frame data.
REQ-015 valid_o  output  1  the output column is valid.
REQ-016 ready_i  input  1  downstream accepts the output column.

Function
REQ-017 A pixel is accepted when valid_i and ready_o are both high. ready_o = !valid_o || ready_i, with no combinational path from valid_i.
REQ-018 Latency: an accepted pixel appears on the outputs with valid_o=1 on the next cycle. Full throughput is one column per cycle while ready_i=1.
REQ-019 Under backpressure (valid_o=1, ready_i=0), all outputs SHALL hold stable, and no RAM read or write SHALL occur.
REQ-020 Column counter: increments on each accept and wraps from LINE_LEN_P-1 to 0. The output eol_o is 1 when the accepted column was LINE_LEN_P-1.
REQ-021 Row FSM states: FILL0 (row 0), FILL1 (row 1), STREAM (row 2 or later).
- FILL0 advances to FILL1 and FILL1 advances to STREAM on a column wrap.
- STREAM holds.
- win_ok_o is 1 only for columns accepted in STREAM.
REQ-022 An accept with sof_i=1 forces column 0 and state FILL0 for that pixel, regardless of the current state. The column counter then continues from 1.
REQ-023 Line storage uses two RAMs of LINE_LEN_P entries: RAM_A holds row n-1 and RAM_B holds row n-2.
REQ-024 On an accept at column c:
- read RAM_A[c] and RAM_B[c];
- write pix_i into RAM_A[c] in the same cycle (read-old-data semantics);
- on the next cycle, write the RAM_A read data into RAM_B[c].
REQ-025 mid_o is the RAM_A read data, top_o is the RAM_B read data, and bot_o is the registered pix_i.
REQ-026 The deferred RAM_B write SHALL NOT be blocked by backpressure.
REQ-027 The deferred RAM_B write SHALL target an address different from any read issued in the same cycle; this is guaranteed by LINE_LEN_P of 2 or more.
REQ-028 RAM contents are never cleared. Stale data is masked only through win_ok_o.

Reset
REQ-029 When rstn_i=0 at a clock edge:
- valid_o, win_ok_o, eol_o, col_o, top_o, mid_o and bot_o SHALL be 0;
- the column counter SHALL be 0;
- the FSM SHALL be FILL0;
- any pending RAM_B write SHALL be dropped.
REQ-030 While rstn_i=0, ready_o SHALL be 0 and no pixel SHALL be accepted.
REQ-031 A reset mid-frame SHALL discard the partial frame. The next accepted pixel SHALL be treated as row 0, column 0, whether or not sof_i is set.

Structure
REQ-032 A shared package, sobel_pkg, SHALL hold the pixel-width constant and the row-FSM enum typedef (FILL0, FILL1, STREAM).
REQ-033 The two line RAMs SHALL be two instances of sync_ram_block (DEPTH_P=LINE_LEN_P). Only read port A of each is used.
REQ-034 No other sub-modules.

Verification (WIDTH_P=8, LINE_LEN_P=4)
REQ-035 Frame fill:
- Stimulus: stream pixels 1..12 continuously, with sof_i on pixel 1 and ready_i=1.
- Required: win_ok_o=0 for outputs 1..8. Output 9 is top=1, mid=5, bot=9, col=0, win_ok=1. Output 12 is top=4, mid=8, bot=12, eol=1.
REQ-036 Backpressure:
- Stimulus: hold ready_i=0 for 3 cycles mid-row 2.
- Required: outputs frozen, ready_o=0, no pixel lost or duplicated, and the sequence matches REQ-035.
REQ-037 Bubbles:
- Stimulus: insert valid_i=0 gaps randomly across pixels 1..12.
- Required: output column values identical to REQ-035.
REQ-038 SOF mid-frame:
- Stimulus: assert sof_i on pixel 7 (row 1, column 2).
- Required: that output has col=0, win_ok=0, and the FSM is in FILL0.
REQ-039 Reset mid-operation:
- Stimulus: drive rstn_i=0 for 1 cycle after pixel 10, then send 12 new pixels without sof_i.
- Required: valid_o=0 during reset. win_ok_o=1 first on new pixel 9, with values from the new frame only.
